// File: rtl/uart_pkg.sv
// Shared types and constants for the confreg UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam int         UART_DATA_BITS = 8;
  localparam logic [7:0] UART_END_BYTE  = 8'hff;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; a push while full is legal only alongside a pop.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/confreg_uart_tx.sv
// 8N1 serialiser for confreg's UART write strobe, with burst FIFO,
// saturating drop counter and a sticky end-of-test flag.
module confreg_uart_tx
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         FIFO_DEPTH   = 16,
  parameter logic [7:0] END_BYTE     = UART_END_BYTE
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        write_uart_valid,
  input  logic [7:0]                  write_uart_data,
  output logic                        txd,
  output logic                        tx_busy,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]                  overflow_count,
  output logic                        end_seen
);
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t    state;
  uart_tx_state_t    state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_reg;
  logic [7:0]        tx_byte;
  logic [7:0]        fifo_dout;
  logic              fifo_empty;
  logic              baud_done;
  logic              push;
  logic              pop;
  logic              txd_nxt;
  logic              end_nxt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  assign baud_done = (baud_cnt == '0);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push      = write_uart_valid && (!fifo_full || pop);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (write_uart_data),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!fifo_empty) state_nxt = START;
      START: if (baud_done) state_nxt = DATA;
      DATA:  if (baud_done && bit_cnt == LAST_BIT) state_nxt = STOP;
      STOP:  if (baud_done) state_nxt = fifo_empty ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    txd_nxt = txd;
    end_nxt = end_seen;
    case (state)
      IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        txd_nxt = 1'b0;
      end
      START: if (baud_done) txd_nxt = shift_reg[0];
      DATA:  if (baud_done) txd_nxt = (bit_cnt == LAST_BIT) ? 1'b1 : shift_reg[1];
      STOP: if (baud_done) begin
        // Back-to-back frames: the next start bit replaces the idle level.
        pop     = !fifo_empty;
        txd_nxt = fifo_empty;
        if (tx_byte == END_BYTE) end_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // Returning to IDLE implies the FIFO was empty, so only a push keeps busy high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      txd            <= 1'b1;
      tx_busy        <= 1'b0;
      end_seen       <= 1'b0;
      overflow_count <= 8'd0;
      baud_cnt       <= BAUD_LOAD;
      bit_cnt        <= 3'd0;
    end else begin
      txd      <= txd_nxt;
      tx_busy  <= (state_nxt != IDLE) || push;
      end_seen <= end_nxt;
      if (write_uart_valid && !push) overflow_count <= sat_inc8(overflow_count);
      if (state == IDLE || baud_done) baud_cnt <= BAUD_LOAD;
      else                            baud_cnt <= baud_cnt - 1'b1;
      if (pop || state == START)           bit_cnt <= 3'd0;
      else if (state == DATA && baud_done) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shift_reg <= fifo_dout;
      tx_byte   <= fifo_dout;
    end else if (state == DATA && baud_done) begin
      shift_reg <= shift_reg >> 1;
    end
  end

endmodule
